// File: rtl/noc_flit_rx_shim.sv
// NoC ejection endpoint: buffers flits from a router output link, packs SERIALIZATION_FACTOR
// flits into one AXI-Stream beat and returns one credit for every buffer slot it frees.
module noc_flit_rx_shim #(
  parameter int TDATA_WIDTH          = 128,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
  parameter int FLIT_BUFFER_DEPTH    = 2
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic                   overflow_err
);

  localparam int SF      = SERIALIZATION_FACTOR;
  localparam int DEPTH   = (FLIT_BUFFER_DEPTH < 1) ? 1 : FLIT_BUFFER_DEPTH;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int IDX_W   = (SF > 1) ? $clog2(SF) : 1;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  // ---------------------------------------------------------------------------
  // Flit FIFO
  // ---------------------------------------------------------------------------
  flit_t            mem_q [DEPTH];
  flit_t            flit_in;
  flit_t            head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign flit_in    = '{data: data_in, dest: dest_in, tail: is_tail_in};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));

  // ---------------------------------------------------------------------------
  // Assembly and output-register state
  // ---------------------------------------------------------------------------
  logic [TDATA_WIDTH-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;
  logic [TDATA_WIDTH-1:0] beat_data;
  logic [DEST_WIDTH-1:0]  beat_dest;
  logic                   beat_done;
  logic                   load, handshake;

  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   credit_q, overflow_q, overflow_d;

  // A flit that would complete a beat may only leave the FIFO if the output register can take it.
  assign beat_done = (idx_q == IDX_W'(SF - 1)) || head.tail;
  assign handshake = tvalid_q && axis_out_tready;
  assign pop       = !fifo_empty && (!beat_done || !tvalid_q || axis_out_tready);
  assign push      = send_in && (!fifo_full || pop);
  assign load      = pop && beat_done;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned
    // and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    asm_d     = asm_q;
    idx_d     = idx_q;
    dest_d    = dest_q;
    beat_data = asm_q;
    beat_dest = (idx_q == '0) ? head.dest : dest_q;
    for (int s = 0; s < SF; s++) begin
      if (idx_q == IDX_W'(s)) beat_data[s*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
    end
    if (pop) begin
      if (beat_done) begin
        asm_d = '0;
        idx_d = '0;
      end else begin
        asm_d = beat_data;
        idx_d = idx_q + 1'b1;
        if (idx_q == '0) dest_d = head.dest;
      end
    end
  end

  always_comb begin
    tvalid_d   = load || (tvalid_q && !handshake);
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tid_d      = tid_q;
    tdest_d    = tdest_q;
    if (load) begin
      tdata_d = beat_data;
      tlast_d = head.tail;
      tid_d   = beat_dest[TDEST_WIDTH +: TID_WIDTH];
      tdest_d = beat_dest[TDEST_WIDTH-1:0];
    end
    overflow_d = overflow_q || (send_in && fifo_full && !pop);
  end

  // NOTE: the flit storage has no reset; the pointers and count decide what is valid, so
  // clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_noc) begin
    if (push) mem_q[wr_ptr_q] <= flit_in;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      idx_q      <= '0;
      dest_q     <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
      tdest_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      dest_q     <= dest_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tid_q      <= tid_d;
      tdest_q    <= tdest_d;
      credit_q   <= pop;
      overflow_q <= overflow_d;
    end
  end

  assign credit_out      = credit_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = tdest_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_noc_flit_rx_shim.sv
// Bench for noc_flit_rx_shim: one instance with single-flit beats (depth 2) and one packing
// four 32-bit flits per beat (depth 4), checked against a packet-level reference model.
module tb_noc_flit_rx_shim;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [1:0]   tid;
    logic [3:0]   tdest;
  } beat_t;

  logic clk_noc = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_noc = ~clk_noc;

  // Instance A: SERIALIZATION_FACTOR=1, depth 2
  logic [127:0] a_data;
  logic [5:0]   a_dest;
  logic         a_tail, a_send, a_ready;
  logic         a_credit, a_tvalid, a_tlast, a_ovf;
  logic [127:0] a_tdata;
  logic [1:0]   a_tid;
  logic [3:0]   a_tdest;

  // Instance B: SERIALIZATION_FACTOR=4, depth 4
  logic [31:0]  b_data;
  logic [5:0]   b_dest;
  logic         b_tail, b_send, b_ready;
  logic         b_credit, b_tvalid, b_tlast, b_ovf;
  logic [127:0] b_tdata;
  logic [1:0]   b_tid;
  logic [3:0]   b_tdest;

  noc_flit_rx_shim #(.SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)) u_dut_a (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(a_data), .dest_in(a_dest),
    .is_tail_in(a_tail), .send_in(a_send), .credit_out(a_credit),
    .axis_out_tvalid(a_tvalid), .axis_out_tready(a_ready), .axis_out_tdata(a_tdata),
    .axis_out_tlast(a_tlast), .axis_out_tid(a_tid), .axis_out_tdest(a_tdest),
    .overflow_err(a_ovf)
  );

  noc_flit_rx_shim #(.SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(4)) u_dut_b (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(b_data), .dest_in(b_dest),
    .is_tail_in(b_tail), .send_in(b_send), .credit_out(b_credit),
    .axis_out_tvalid(b_tvalid), .axis_out_tready(b_ready), .axis_out_tdata(b_tdata),
    .axis_out_tlast(b_tlast), .axis_out_tid(b_tid), .axis_out_tdest(b_tdest),
    .overflow_err(b_ovf)
  );

  int    total = 0;
  int    bad   = 0;
  beat_t a_got[$];
  beat_t b_got[$];
  logic  a_vh[$];
  logic  b_vh[$];
  int    a_cred, b_cred;

  // Each step occupies one clock cycle: inputs applied just after the rising edge,
  // outputs observed on the falling edge.
  task automatic step_a(input logic send, input logic [127:0] d, input logic [5:0] dst,
                        input logic tail, input logic rdy);
    beat_t bt;
    a_send = send; a_data = d; a_dest = dst; a_tail = tail; a_ready = rdy;
    b_send = 1'b0;
    @(negedge clk_noc);
    a_vh.push_back(a_tvalid);
    if (a_credit) a_cred++;
    if (a_tvalid && rdy) begin
      bt.data = a_tdata; bt.last = a_tlast; bt.tid = a_tid; bt.tdest = a_tdest;
      a_got.push_back(bt);
    end
    @(posedge clk_noc); #1;
  endtask

  task automatic step_b(input logic send, input logic [31:0] d, input logic [5:0] dst,
                        input logic tail, input logic rdy);
    beat_t bt;
    b_send = send; b_data = d; b_dest = dst; b_tail = tail; b_ready = rdy;
    a_send = 1'b0;
    @(negedge clk_noc);
    b_vh.push_back(b_tvalid);
    if (b_credit) b_cred++;
    if (b_tvalid && rdy) begin
      bt.data = b_tdata; bt.last = b_tlast; bt.tid = b_tid; bt.tdest = b_tdest;
      b_got.push_back(bt);
    end
    @(posedge clk_noc); #1;
  endtask

  task automatic clear_logs();
    a_got.delete(); b_got.delete(); a_vh.delete(); b_vh.delete();
    a_cred = 0; b_cred = 0;
  endtask

  task automatic apply_reset();
    a_send = 0; a_data = '0; a_dest = '0; a_tail = 0; a_ready = 0;
    b_send = 0; b_data = '0; b_dest = '0; b_tail = 0; b_ready = 0;
    @(negedge clk_noc);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_noc);
    rst_n = 1'b1;
    @(posedge clk_noc); #1;
    clear_logs();
  endtask

  task automatic check_beat(input string name, input beat_t got, input beat_t exp);
    total++;
    if (got.data !== exp.data || got.last !== exp.last || got.tid !== exp.tid ||
        got.tdest !== exp.tdest) begin
      bad++;
      $display("FAIL %s: got data=%h last=%b tid=%0d tdest=%0d, want data=%h last=%b tid=%0d tdest=%0d",
               name, got.data, got.last, got.tid, got.tdest, exp.data, exp.last, exp.tid, exp.tdest);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [127:0] d, input logic l, input logic [5:0] dst);
    beat_t b;
    b.data = d; b.last = l; b.tid = dst[5:4]; b.tdest = dst[3:0];
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({a_tvalid, a_tdata, a_tlast, a_tid, a_tdest, a_credit, a_ovf} !== '0) begin
      bad++; $display("FAIL reset_a: outputs not all zero (tvalid=%b credit=%b)", a_tvalid, a_credit);
    end
    total++;
    if ({b_tvalid, b_tdata, b_tlast, b_tid, b_tdest, b_credit, b_ovf} !== '0) begin
      bad++; $display("FAIL reset_b: outputs not all zero (tvalid=%b credit=%b)", b_tvalid, b_credit);
    end
    apply_reset();
    repeat (3) step_a(1'b0, '0, '0, 1'b0, 1'b1);
    check_int("reset_idle_beats_a", a_got.size(), 0);
    check_int("reset_idle_credits_a", a_cred, 0);
  endtask

  task automatic test_single_flit();
    apply_reset();
    step_a(1'b1, 128'hDEAD_BEEF, 6'b10_0111, 1'b1, 1'b1);
    repeat (5) step_a(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (a_vh[i] !== (i == 2)) begin
        bad++; $display("FAIL single_tvalid_cycle%0d: got %b want %b", i, a_vh[i], (i == 2));
      end
    end
    check_int("single_credits", a_cred, 1);
    check_int("single_beats", a_got.size(), 1);
    if (a_got.size() == 1) check_beat("single_beat", a_got[0], mk(128'hDEAD_BEEF, 1'b1, 6'b10_0111));
  endtask

  task automatic test_full_reassembly();
    logic [31:0] f [4];
    f[0] = 32'h11111111; f[1] = 32'h22222222; f[2] = 32'h33333333; f[3] = 32'h44444444;
    apply_reset();
    for (int k = 0; k < 4; k++) step_b(1'b1, f[k], 6'b01_0011, (k == 3), 1'b1);
    repeat (6) step_b(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (b_vh[i] !== (i == 5)) begin
        bad++; $display("FAIL reasm_tvalid_cycle%0d: got %b want %b", i, b_vh[i], (i == 5));
      end
    end
    check_int("reasm_credits", b_cred, 4);
    check_int("reasm_beats", b_got.size(), 1);
    if (b_got.size() == 1)
      check_beat("reasm_beat", b_got[0],
                 mk(128'h44444444_33333333_22222222_11111111, 1'b1, 6'b01_0011));
  endtask

  task automatic test_partial_tail();
    apply_reset();
    step_b(1'b1, 32'hAAAAAAAA, 6'b11_0001, 1'b0, 1'b1);
    step_b(1'b1, 32'hBBBBBBBB, 6'b00_0000, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step_b(1'b1, 32'h55555555 + 32'h11111111 * k, 6'b00_1010, (k == 3), 1'b1);
    repeat (8) step_b(1'b0, '0, '0, 1'b0, 1'b1);
    check_int("partial_beats", b_got.size(), 2);
    check_int("partial_credits", b_cred, 6);
    if (b_got.size() == 2) begin
      check_beat("partial_beat0", b_got[0], mk({64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA}, 1'b1, 6'b11_0001));
      check_beat("partial_beat1", b_got[1],
                 mk(128'h88888888_77777777_66666666_55555555, 1'b1, 6'b00_1010));
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step_a(1'b1, 128'h0123, 6'b01_0101, 1'b0, 1'b0);
    step_a(1'b1, 128'h4567, 6'b10_1010, 1'b1, 1'b0);
    repeat (4) step_a(1'b0, '0, '0, 1'b0, 1'b0);
    check_int("bp_hold_tvalid", a_tvalid, 1);
    total++;
    if (a_tdata !== 128'h0123) begin
      bad++; $display("FAIL bp_hold_tdata: got %h want %h", a_tdata, 128'h0123);
    end
    check_int("bp_hold_credits", a_cred, 1);
    repeat (4) step_a(1'b0, '0, '0, 1'b0, 1'b1);
    check_int("bp_beats", a_got.size(), 2);
    if (a_got.size() == 2) begin
      check_beat("bp_beat0", a_got[0], mk(128'h0123, 1'b0, 6'b01_0101));
      check_beat("bp_beat1", a_got[1], mk(128'h4567, 1'b1, 6'b10_1010));
    end
    check_int("bp_credits", a_cred, 2);
    check_int("bp_no_overflow", a_ovf, 0);
    check_int("bp_tvalid_low", a_tvalid, 0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 1; k <= 4; k++) step_a(1'b1, 128'(k * 16'h1111), 6'b00_0001, 1'b1, 1'b0);
    repeat (2) step_a(1'b0, '0, '0, 1'b0, 1'b0);
    check_int("ovf_set", a_ovf, 1);
    check_int("ovf_stall_credits", a_cred, 1);
    repeat (6) step_a(1'b0, '0, '0, 1'b0, 1'b1);
    check_int("ovf_beats", a_got.size(), 3);
    for (int k = 0; k < 3 && k < a_got.size(); k++)
      check_beat($sformatf("ovf_beat%0d", k), a_got[k], mk(128'((k + 1) * 16'h1111), 1'b1, 6'b00_0001));
    check_int("ovf_credits", a_cred, 3);
    check_int("ovf_sticky", a_ovf, 1);
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    for (int k = 0; k < 4; k++) step_b(1'b1, 32'hC0C0_0000 + k, 6'b10_0101, (k == 3), 1'b0);
    step_b(1'b1, 32'hDEAD_0001, 6'b10_0101, 1'b0, 1'b0);
    step_b(1'b1, 32'hDEAD_0002, 6'b10_0101, 1'b0, 1'b0);
    repeat (3) step_b(1'b0, '0, '0, 1'b0, 1'b0);
    check_int("rmid_pre_tvalid", b_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({b_tvalid, b_tdata, b_tlast, b_tid, b_tdest, b_credit, b_ovf} !== '0) begin
      bad++; $display("FAIL rmid_async_zero: tvalid=%b tdata=%h credit=%b", b_tvalid, b_tdata, b_credit);
    end
    @(negedge clk_noc);
    rst_n = 1'b1;
    @(posedge clk_noc); #1;
    clear_logs();
    for (int k = 0; k < 4; k++) step_b(1'b1, 32'h0A0A_0A00 + k, 6'b01_1100, (k == 3), 1'b1);
    repeat (8) step_b(1'b0, '0, '0, 1'b0, 1'b1);
    check_int("rmid_beats", b_got.size(), 1);
    if (b_got.size() == 1)
      check_beat("rmid_beat", b_got[0],
                 mk(128'h0A0A0A03_0A0A0A02_0A0A0A01_0A0A0A00, 1'b1, 6'b01_1100));
    check_int("rmid_credits", b_cred, 4);
  endtask

  // Credit-respecting random traffic; expected beats are built by packing the sent flits.
  task automatic test_random();
    beat_t        exp_q[$];
    logic [127:0] cur_data;
    logic [5:0]   cur_dest;
    int           slot, avail, nsent, cred_before;
    logic         snd, tl, rdy;
    logic [31:0]  d;
    logic [5:0]   dst;
    apply_reset();
    cur_data = '0; cur_dest = '0; slot = 0; avail = 4; nsent = 0;
    for (int c = 0; c < 600; c++) begin
      snd = (avail > 0) && ($urandom_range(0, 3) != 0);
      d   = $urandom;
      dst = 6'($urandom_range(0, 63));
      tl  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (snd) begin
        avail--; nsent++;
        if (slot == 0) cur_dest = dst;
        cur_data[slot*32 +: 32] = d;
        if (slot == 3 || tl) begin
          exp_q.push_back(mk(cur_data, tl, cur_dest));
          cur_data = '0; slot = 0;
        end else begin
          slot++;
        end
      end
      cred_before = b_cred;
      step_b(snd, d, dst, tl, rdy);
      avail += b_cred - cred_before;
    end
    repeat (20) step_b(1'b0, '0, '0, 1'b0, 1'b1);
    check_int("rand_beats", b_got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < b_got.size(); i++)
      check_beat($sformatf("rand_beat%0d", i), b_got[i], exp_q[i]);
    check_int("rand_credits", b_cred, nsent);
    check_int("rand_no_overflow", b_ovf, 0);
  endtask

  initial begin
    a_send = 0; a_data = '0; a_dest = '0; a_tail = 0; a_ready = 0;
    b_send = 0; b_data = '0; b_dest = '0; b_tail = 0; b_ready = 0;
    clear_logs();
    test_reset();
    test_single_flit();
    test_full_reassembly();
    test_partial_tail();
    test_backpressure();
    test_overflow();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
